btb_assoc: RTL and testbench
============================

# btb_assoc

Set-associative branch target buffer with init-sweep reset, per-set pseudo-LRU replacement and optional 2-bit direction counters. Sits beside the fetch-stage PC mux: looks up `pc_F` combinationally and supplies a predicted target and taken flag. It is trained from the execute stage with resolved branches and jumps. It supersedes the direct-mapped, always-taken BTB of the current pipeline.

## Interface
- `ENTRIES`, 256: total entries; power of two, ≥ `WAYS`.
- `WAYS`, 2: associativity; one of 1, 2, 4.
- `XLEN`, 32: PC/target width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `flush_all` in 1: one-cycle pulse; invalidate every entry (FENCE.I / context switch).
- `ready` out 1: 0 while the invalidate sweep runs.
- `pc_F` in XLEN: fetch PC to look up.
- `hit_F` out 1: valid tag match in the indexed set.
- `taken_F` out 1: predict taken; use `target_F`.
- `target_F` out XLEN: predicted target; 0 when `hit_F`=0.
- `upd_valid_E` in 1: training request this cycle.
- `upd_pc_E` in XLEN: PC of the resolved control-flow instruction.
- `upd_target_E` in XLEN: resolved target.
- `upd_taken_E` in 1: resolved direction.
- `upd_jump_E` in 1: instruction is JAL/JALR; always taken.

## Operation
- Address split:
  - `SETS = ENTRIES/WAYS`, `IDX_W = log2(SETS)`.
  - Index = `pc[IDX_W+1:2]`; tag = `pc[XLEN-1:IDX_W+2]`; `pc[1:0]` is ignored.
- Entry fields: valid, tag, target (XLEN), ctr (2 bits, `BTB_BHT_EN` only). Per set: PLRU state, `WAYS-1` bits (0 bits for `WAYS`=1).
- Lookup (combinational):
  - `hit_F` = any way valid with tag equal.
  - At most one way may match; update logic guarantees this.
  - `target_F` comes from the matching way.
- Update (registered at `clk`, only when `ready`=1 and `upd_valid_E`=1):
  - Tag hit in way w:
    - write target to w;
    - adjust ctr: jump → 2'b11; taken → +1 saturating at 3; not taken → −1 saturating at 0;
    - touch PLRU toward w.
  - Tag miss, taken or jump: allocate a victim way.
    - Victim = lowest-numbered invalid way, else the PLRU victim.
    - Write valid=1, tag, target; ctr = 2'b11 for a jump, 2'b10 for a taken branch.
    - Touch PLRU toward the victim.
  - Tag miss, not taken: no state change.
- Invalidate FSM:
  - States:
    - IDLE (`ready`=1);
    - SWEEP (`ready`=0; counter `set_q` clears valid and PLRU of one set per cycle, 0..SETS-1).
  - Transitions:
    - `!rst_n` → SWEEP with `set_q`=0;
    - `flush_all` in IDLE → SWEEP with `set_q`=0;
    - SWEEP at `set_q`=SETS-1 → IDLE.
  - During SWEEP: `hit_F`=0, `taken_F`=0, `target_F`=0; updates are dropped.
  - `flush_all` during SWEEP restarts the counter at 0.
  - `rst_n` low mid-sweep restarts the sweep.

## Timing
- Lookup latency 0 cycles: outputs are combinational from `pc_F` and array state.
- An update is visible to lookup from the cycle after its clock edge.
- Same-cycle lookup and update of the same set: lookup returns the pre-update contents; there is no bypass.
- Reset values:
  - `ready`=0 for exactly SETS cycles after `rst_n` returns high, then 1;
  - `hit_F`/`taken_F`/`target_F` = 0 throughout.
- Target and tag arrays are not reset; only valid, PLRU and ctr are cleared.
- `flush_all` asserted: `ready` falls on the next edge. Sweep takes SETS cycles.

## Configuration
- `BTB_BHT_EN` defined:
  - ctr storage present;
  - `taken_F` = `hit_F & ctr[1]`.
- `BTB_BHT_EN` undefined:
  - no ctr storage;
  - `taken_F` = `hit_F`;
  - a not-taken update that hits clears that entry's valid bit;
  - PLRU is still touched toward that way.

## Structure
- Package `btb_pkg` holds:
  - ctr encodings: `CTR_SNT`=0, `CTR_WNT`=1, `CTR_WT`=2, `CTR_ST`=3;
  - the entry typedef (valid/tag/target/ctr);
  - a `clog2` helper.
- Sub-module `btb_plru`: tree pseudo-LRU for 1/2/4 ways.
  - Pure combinational.
  - Inputs: set PLRU bits, touched way.
  - Outputs: next PLRU bits, victim way.
- Top level holds the arrays and the sweep FSM.

## Test plan
- Reset → `ready`=0 for 128 cycles (256/2), then 1. Any `pc_F` gives `hit_F`=0, `target_F`=0.
- Update pc 0x0000_1000, target 0x0000_2000, taken → next cycle `pc_F`=0x1000 gives hit=1, taken=1, target 0x2000. `pc_F`=0x0000_1200 (same set, different tag) gives hit=0.
- Three taken branches mapping to set 0 (0x000, 0x200, 0x400), then lookup 0x200 → 0x000 evicted, 0x200 and 0x400 hit.
- `BTB_BHT_EN`: allocate taken (ctr=2), two not-taken updates → ctr=0, hit=1, taken=0; two taken updates → taken=1.
- Without `BTB_BHT_EN`: a not-taken update on a hit entry → next lookup hit=0.
- `flush_all` mid-operation with an update in the same cycle → update dropped, `ready`=0 for 128 cycles, all lookups miss afterward.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared constants, per-entry metadata type and sizing helpers for btb_assoc.
// The ctr field exists only when BTB_BHT_EN is defined.
package btb_pkg;

    localparam logic [1:0] CTR_SNT = 2'd0;
    localparam logic [1:0] CTR_WNT = 2'd1;
    localparam logic [1:0] CTR_WT  = 2'd2;
    localparam logic [1:0] CTR_ST  = 2'd3;

    // Tag and target sit in separate arrays that are never cleared; this is the
    // part of an entry that the invalidate sweep resets.
    typedef struct packed {
        logic       valid;
`ifdef BTB_BHT_EN
        logic [1:0] ctr;
`endif
    } btb_meta_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r++;
        end
        return r;
    endfunction

    function automatic int unsigned way_bits(input int unsigned ways);
        return (ways > 1) ? clog2(ways) : 1;
    endfunction

    // One dummy bit keeps the 1-way build legal; it never affects the victim.
    function automatic int unsigned plru_bits(input int unsigned ways);
        return (ways > 1) ? ways - 1 : 1;
    endfunction

endpackage

// File: rtl/btb_plru.sv
// Tree pseudo-LRU for 1, 2 or 4 ways: next state after touching a way, and the
// current victim. Each tree bit points at the less recently used side.
module btb_plru
    import btb_pkg::*;
#(
    parameter int unsigned WAYS = 2
) (
    input  logic [plru_bits(WAYS)-1:0] plru_i,
    input  logic [way_bits(WAYS)-1:0]  touch_i,
    output logic [plru_bits(WAYS)-1:0] plru_o,
    output logic [way_bits(WAYS)-1:0]  victim_o
);

    if (WAYS == 4) begin : g_w4
        always_comb begin
            plru_o    = plru_i;
            plru_o[0] = ~touch_i[1];
            if (touch_i[1]) begin
                plru_o[2] = ~touch_i[0];
            end else begin
                plru_o[1] = ~touch_i[0];
            end
            victim_o = plru_i[0] ? {1'b1, plru_i[2]} : {1'b0, plru_i[1]};
        end
    end else if (WAYS == 2) begin : g_w2
        assign plru_o   = ~touch_i;
        assign victim_o = plru_i;
    end else begin : g_w1
        logic unused_touch;
        assign unused_touch = ^touch_i;
        assign plru_o       = plru_i;
        assign victim_o     = '0;
    end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB with init-sweep invalidate and tree-PLRU replacement.
// Define BTB_BHT_EN to add 2-bit direction counters per entry.
module btb_assoc
    import btb_pkg::*;
#(
    parameter int unsigned ENTRIES = 256,
    parameter int unsigned WAYS    = 2,
    parameter int unsigned XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_all,
    output logic            ready,
    input  logic [XLEN-1:0] pc_F,
    output logic            hit_F,
    output logic            taken_F,
    output logic [XLEN-1:0] target_F,
    input  logic            upd_valid_E,
    input  logic [XLEN-1:0] upd_pc_E,
    input  logic [XLEN-1:0] upd_target_E,
    input  logic            upd_taken_E,
    input  logic            upd_jump_E
);

    localparam int unsigned SETS   = ENTRIES / WAYS;
    localparam int unsigned IDX_W  = clog2(SETS);
    localparam int unsigned TAG_W  = XLEN - IDX_W - 2;
    localparam int unsigned WAY_W  = way_bits(WAYS);
    localparam int unsigned PLRU_W = plru_bits(WAYS);

    typedef enum logic [0:0] {StIdle, StSweep} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] set_q, set_d;

    btb_meta_t         meta_q   [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q    [SETS][WAYS];
    logic [XLEN-1:0]   target_q [SETS][WAYS];
    logic [PLRU_W-1:0] plru_q   [SETS];

    logic [IDX_W-1:0]  f_idx, u_idx;
    logic [TAG_W-1:0]  f_tag, u_tag;
    logic              upd_en, eff_taken, u_hit, inv_found, wr_en;
    logic [WAY_W-1:0]  hit_way, inv_way, wr_way, plru_victim;
    logic [PLRU_W-1:0] plru_next;
    btb_meta_t         wr_meta;

    logic unused_pc;
    assign unused_pc = ^{pc_F[1:0], upd_pc_E[1:0]};

    // Sweep FSM: state register, next state, outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StSweep;
            set_q   <= '0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
        end
    end

    always_comb begin
        state_d = state_q;
        set_d   = set_q;
        unique case (state_q)
            StIdle: begin
                if (flush_all) begin
                    state_d = StSweep;
                    set_d   = '0;
                end
            end
            StSweep: begin
                if (flush_all) begin
                    set_d = '0;
                end else if (set_q == IDX_W'(SETS - 1)) begin
                    state_d = StIdle;
                end else begin
                    set_d = set_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = StSweep;
                set_d   = '0;
            end
        endcase
    end

    always_comb begin
        ready = (state_q == StIdle);
    end

    // Lookup: combinational, sees pre-update array contents.
    always_comb begin
        f_idx    = pc_F[IDX_W+1:2];
        f_tag    = pc_F[XLEN-1:IDX_W+2];
        hit_F    = 1'b0;
        taken_F  = 1'b0;
        target_F = '0;
        if (ready) begin
            for (int w = 0; w < WAYS; w++) begin
                if (meta_q[f_idx][w].valid && (tag_q[f_idx][w] == f_tag)) begin
                    hit_F    = 1'b1;
                    target_F = target_F | target_q[f_idx][w];
`ifdef BTB_BHT_EN
                    taken_F  = taken_F | meta_q[f_idx][w].ctr[1];
`else
                    taken_F  = 1'b1;
`endif
                end
            end
        end
    end

    // Training: pick the way to write and the metadata it receives.
    always_comb begin
        u_idx     = upd_pc_E[IDX_W+1:2];
        u_tag     = upd_pc_E[XLEN-1:IDX_W+2];
        eff_taken = upd_taken_E | upd_jump_E;
        upd_en    = ready & upd_valid_E & ~flush_all;
        u_hit     = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        // Descending scan so the lowest-numbered invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (meta_q[u_idx][w].valid && (tag_q[u_idx][w] == u_tag)) begin
                u_hit   = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!meta_q[u_idx][w].valid) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        wr_way  = u_hit ? hit_way : (inv_found ? inv_way : plru_victim);
        wr_en   = upd_en & (u_hit | eff_taken);
        wr_meta = '0;
`ifdef BTB_BHT_EN
        wr_meta.valid = 1'b1;
        if (!u_hit) begin
            wr_meta.ctr = upd_jump_E ? CTR_ST : CTR_WT;
        end else if (upd_jump_E) begin
            wr_meta.ctr = CTR_ST;
        end else if (upd_taken_E) begin
            wr_meta.ctr = (meta_q[u_idx][hit_way].ctr == CTR_ST) ?
                          CTR_ST : meta_q[u_idx][hit_way].ctr + 2'd1;
        end else begin
            wr_meta.ctr = (meta_q[u_idx][hit_way].ctr == CTR_SNT) ?
                          CTR_SNT : meta_q[u_idx][hit_way].ctr - 2'd1;
        end
`else
        // Without counters a not-taken hit drops the entry.
        wr_meta.valid = eff_taken;
`endif
    end

    btb_plru #(
        .WAYS (WAYS)
    ) u_plru (
        .plru_i   (plru_q[u_idx]),
        .touch_i  (wr_way),
        .plru_o   (plru_next),
        .victim_o (plru_victim)
    );

    always_ff @(posedge clk) begin
        if (state_q == StSweep) begin
            for (int w = 0; w < WAYS; w++) begin
                meta_q[set_q][w] <= '0;
            end
            plru_q[set_q] <= '0;
        end else if (wr_en) begin
            meta_q[u_idx][wr_way]   <= wr_meta;
            tag_q[u_idx][wr_way]    <= u_tag;
            target_q[u_idx][wr_way] <= upd_target_E;
            plru_q[u_idx]           <= plru_next;
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc (default 256 entries, 2 ways, 32-bit PC).
module tb_btb_assoc;

    logic        clk = 1'b0;
    logic        rst_n, flush_all, ready, hit_F, taken_F;
    logic        upd_valid_E, upd_taken_E, upd_jump_E;
    logic [31:0] pc_F, target_F, upd_pc_E, upd_target_E;
    int          total = 0;
    int          bad   = 0;
    int          cnt;

    always #5 clk = ~clk;

    btb_assoc dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_all    (flush_all),
        .ready        (ready),
        .pc_F         (pc_F),
        .hit_F        (hit_F),
        .taken_F      (taken_F),
        .target_F     (target_F),
        .upd_valid_E  (upd_valid_E),
        .upd_pc_E     (upd_pc_E),
        .upd_target_E (upd_target_E),
        .upd_taken_E  (upd_taken_E),
        .upd_jump_E   (upd_jump_E)
    );

    typedef struct {
        logic        do_upd;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic        utaken;
        logic        ujump;
        logic [31:0] lpc;
        logic        ehit;
        logic        etaken;
        logic [31:0] etgt;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic look(input string nm, input logic [31:0] pc, input logic h,
                        input logic t, input logic [31:0] tg);
        pc_F = pc;
        #1;
        chk({nm, ".hit"}, 32'(hit_F), 32'(h));
        chk({nm, ".taken"}, 32'(taken_F), 32'(t));
        chk({nm, ".target"}, target_F, tg);
    endtask

    task automatic train(input logic [31:0] pc, input logic [31:0] tg, input logic tk,
                         input logic jp);
        @(negedge clk);
        upd_pc_E     = pc;
        upd_target_E = tg;
        upd_taken_E  = tk;
        upd_jump_E   = jp;
        upd_valid_E  = 1'b1;
        @(negedge clk);
        upd_valid_E  = 1'b0;
    endtask

    // Counts negedges with ready low; optionally pulses flush at one of them.
    task automatic count_low(input int flush_at, output int n);
        n = 0;
        while (!ready && n < 1000) begin
            flush_all = (n == flush_at);
            n++;
            @(negedge clk);
            #1;
        end
        flush_all = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_1000, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h0000_1000, 32'h0000_2000, 1'b1, 1'b0, 32'h0000_1000, 1'b1, 1'b1, 32'h0000_2000};
        vecs[2]  = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_1200, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_1002, 1'b1, 1'b1, 32'h0000_2000};
        vecs[4]  = '{1'b1, 32'h0000_1200, 32'h0000_3000, 1'b0, 1'b0, 32'h0000_1200, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 32'h0000_1200, 32'h0000_3000, 1'b0, 1'b1, 32'h0000_1200, 1'b1, 1'b1, 32'h0000_3000};
        vecs[6]  = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_1000, 1'b1, 1'b1, 32'h0000_2000};
        vecs[7]  = '{1'b1, 32'h0000_1000, 32'h0000_2400, 1'b1, 1'b0, 32'h0000_1000, 1'b1, 1'b1, 32'h0000_2400};
        vecs[8]  = '{1'b1, 32'h0000_1400, 32'h0000_5000, 1'b1, 1'b0, 32'h0000_1200, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_1400, 1'b1, 1'b1, 32'h0000_5000};
        vecs[10] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_1000, 1'b1, 1'b1, 32'h0000_2400};
        vecs[11] = '{1'b1, 32'h0000_1004, 32'h0000_8888, 1'b1, 1'b0, 32'h0000_1004, 1'b1, 1'b1, 32'h0000_8888};
        vecs[12] = '{1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h1234_5678};
        vecs[13] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h7FFF_FFFC, 1'b0, 1'b0, 32'h0};

        rst_n        = 1'b0;
        flush_all    = 1'b0;
        pc_F         = 32'h0;
        upd_valid_E  = 1'b0;
        upd_pc_E     = 32'h0;
        upd_target_E = 32'h0;
        upd_taken_E  = 1'b0;
        upd_jump_E   = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst.ready", 32'(ready), 32'd0);
        chk("rst.hit", 32'(hit_F), 32'd0);
        rst_n = 1'b1;
        count_low(-1, cnt);
        chk("rst.sweep_cycles", cnt, 128);
        look("post_rst", 32'h0000_1000, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].do_upd) begin
                train(vecs[i].upc, vecs[i].utgt, vecs[i].utaken, vecs[i].ujump);
            end else begin
                @(negedge clk);
            end
            look($sformatf("vec%0d", i), vecs[i].lpc, vecs[i].ehit, vecs[i].etaken,
                 vecs[i].etgt);
        end

        // Flush with a same-cycle update: update dropped, lookups blanked.
        @(negedge clk);
        flush_all    = 1'b1;
        upd_valid_E  = 1'b1;
        upd_pc_E     = 32'h0000_1008;
        upd_target_E = 32'h0000_9999;
        upd_taken_E  = 1'b1;
        upd_jump_E   = 1'b0;
        @(negedge clk);
        flush_all   = 1'b0;
        upd_valid_E = 1'b0;
        look("sweep_blank", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        count_low(-1, cnt);
        chk("flush.sweep_cycles", cnt, 128);
        look("flush.a", 32'h0000_1000, 1'b0, 1'b0, 32'h0);
        look("flush.b", 32'h0000_1400, 1'b0, 1'b0, 32'h0);
        look("flush.c", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        look("flush.dropped", 32'h0000_1008, 1'b0, 1'b0, 32'h0);

        // Set-0 eviction: 0x000 is the PLRU victim for the third allocation.
        train(32'h0000_0000, 32'h0000_00A0, 1'b1, 1'b0);
        train(32'h0000_0200, 32'h0000_00A2, 1'b1, 1'b0);
        train(32'h0000_0400, 32'h0000_00A4, 1'b1, 1'b0);
        look("evict.200", 32'h0000_0200, 1'b1, 1'b1, 32'h0000_00A2);
        look("evict.400", 32'h0000_0400, 1'b1, 1'b1, 32'h0000_00A4);
        look("evict.000", 32'h0000_0000, 1'b0, 1'b0, 32'h0);

        // Direction behaviour on a hitting entry.
        train(32'h0000_3008, 32'h0000_3100, 1'b1, 1'b0);
        look("dir.alloc", 32'h0000_3008, 1'b1, 1'b1, 32'h0000_3100);
        train(32'h0000_3008, 32'h0000_3100, 1'b0, 1'b0);
`ifdef BTB_BHT_EN
        look("dir.nt1", 32'h0000_3008, 1'b1, 1'b0, 32'h0000_3100);
        train(32'h0000_3008, 32'h0000_3100, 1'b0, 1'b0);
        look("dir.nt2", 32'h0000_3008, 1'b1, 1'b0, 32'h0000_3100);
        train(32'h0000_3008, 32'h0000_3100, 1'b1, 1'b0);
        look("dir.t1", 32'h0000_3008, 1'b1, 1'b0, 32'h0000_3100);
        train(32'h0000_3008, 32'h0000_3100, 1'b1, 1'b0);
        look("dir.t2", 32'h0000_3008, 1'b1, 1'b1, 32'h0000_3100);
`else
        look("dir.nt_inval", 32'h0000_3008, 1'b0, 1'b0, 32'h0);
`endif

        // Flush restarted mid-sweep, with updates held during the sweep.
        @(negedge clk);
        flush_all = 1'b1;
        @(negedge clk);
        #1;
        upd_valid_E  = 1'b1;
        upd_pc_E     = 32'h0000_1010;
        upd_target_E = 32'h0000_7777;
        upd_taken_E  = 1'b1;
        count_low(20, cnt);
        upd_valid_E = 1'b0;
        chk("restart.sweep_cycles", cnt, 149);
        look("restart.dropped", 32'h0000_1010, 1'b0, 1'b0, 32'h0);
        look("restart.cleared", 32'h0000_0200, 1'b0, 1'b0, 32'h0);

        // Reset in normal operation re-runs the sweep.
        train(32'h0000_0600, 32'h0000_0AAA, 1'b1, 1'b0);
        look("rst2.pre", 32'h0000_0600, 1'b1, 1'b1, 32'h0000_0AAA);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        count_low(-1, cnt);
        chk("rst2.sweep_cycles", cnt, 128);
        look("rst2.post", 32'h0000_0600, 1'b0, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
